// File: rtl/sshooter_audio_pkg.sv
// Shared types and constants for the post-YM2203 audio mixer.
package sshooter_audio_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH_A = 3'd1,
    CH_B = 3'd2,
    CH_C = 3'd3,
    FM   = 3'd4,
    MIX  = 3'd5
  } mix_state_t;

  localparam int SAMPLE_W = 16;
  localparam int MIX_W    = 20;
  localparam int TERM_W   = 21;

  localparam int DCRM_SHIFT_DEF = 10;
  localparam int LPF_SHIFT_DEF  = 7;
  localparam int FM_SHIFT_DEF   = 4;
  localparam int SSG_GAIN_DEF   = 21;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [MIX_W:0] v);
    if (v > 21'sd32767)
      return 16'sh7fff;
    else if (v < -21'sd32768)
      return 16'sh8000;
    else
      return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sshooter_onepole.sv
// Combinational one-pole update: y = acc >>> SHIFT, acc_next = acc + x - y.
module sshooter_onepole
  import sshooter_audio_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic signed [SAMPLE_W+SHIFT-1:0] acc_i,
  input  logic signed [SAMPLE_W-1:0]       x_i,
  output logic signed [SAMPLE_W-1:0]       y_o,
  output logic signed [SAMPLE_W+SHIFT-1:0] acc_next_o
);

  localparam int ACC_W = SAMPLE_W + SHIFT;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted    = acc_i >>> SHIFT;
    y_o        = shifted[SAMPLE_W-1:0];
    acc_next_o = acc_i + ACC_W'(x_i) - ACC_W'(y_o);
  end

endmodule

// File: rtl/sshooter_audio_mixer.sv
// Time-multiplexed SSG/FM mixer: DC removal + switchable LPF per SSG channel, gain, mix, saturate.
// Optional FM low-pass stage built when SSHOOTER_FM_LPF_EN is defined.
//
// state | meaning
// IDLE  | wait for sample_cen, capture inputs
// CH_A  | SSG A through shared DC/LPF datapath
// CH_B  | SSG B through shared DC/LPF datapath
// CH_C  | SSG C through shared DC/LPF datapath
// FM    | latch FM term (raw or filtered)
// MIX   | sum, double, clamp, register sound
module sshooter_audio_mixer
  import sshooter_audio_pkg::*;
#(
  parameter int DCRM_SHIFT = DCRM_SHIFT_DEF,
  parameter int LPF_SHIFT  = LPF_SHIFT_DEF,
  parameter int FM_SHIFT   = FM_SHIFT_DEF,
  parameter int SSG_GAIN   = SSG_GAIN_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_cen,
  input  logic signed [SAMPLE_W-1:0] fm_in,
  input  logic [7:0]                 ssg_a,
  input  logic [7:0]                 ssg_b,
  input  logic [7:0]                 ssg_c,
  input  logic [2:0]                 filter_en,
  output logic signed [SAMPLE_W-1:0] sound,
  output logic                       out_valid,
  output logic                       overrun
);

  localparam int DC_W = SAMPLE_W + DCRM_SHIFT;
  localparam int LP_W = SAMPLE_W + LPF_SHIFT;

  mix_state_t                 state_q;
  logic signed [SAMPLE_W-1:0] fm_q;
  logic [7:0]                 ssg_q    [3];
  logic [2:0]                 fen_q;
  logic signed [DC_W-1:0]     dc_acc_q [3];
  logic signed [LP_W-1:0]     lp_acc_q [3];
  logic signed [TERM_W-1:0]   term_q   [3];
  logic signed [SAMPLE_W-1:0] fm_term_q;

  logic [1:0]                 ch;
  logic signed [SAMPLE_W-1:0] x_d, dc_y, xd_d, lp_y, sel_d, sel_sh;
  logic signed [DC_W-1:0]     dc_acc_d;
  logic signed [LP_W-1:0]     lp_acc_d;
  logic signed [TERM_W-1:0]   term_d;
  logic signed [SAMPLE_W-1:0] fm_term_d;
  logic signed [MIX_W-1:0]    sum_d;
  logic signed [MIX_W:0]      s2_d;

  always_comb begin
    ch = 2'd0;
    case (state_q)
      CH_B:    ch = 2'd1;
      CH_C:    ch = 2'd2;
      default: ch = 2'd0;
    endcase
  end

  assign x_d = $signed({3'd0, ssg_q[ch], 5'd0});

  sshooter_onepole #(.SHIFT(DCRM_SHIFT)) u_dc (
    .acc_i      (dc_acc_q[ch]),
    .x_i        (x_d),
    .y_o        (dc_y),
    .acc_next_o (dc_acc_d)
  );

  assign xd_d = x_d - dc_y;

  sshooter_onepole #(.SHIFT(LPF_SHIFT)) u_lp (
    .acc_i      (lp_acc_q[ch]),
    .x_i        (xd_d),
    .y_o        (lp_y),
    .acc_next_o (lp_acc_d)
  );

  // filter_en is MSB-first: bit 2 is channel A
  assign sel_d  = fen_q[2'd2 - ch] ? lp_y : xd_d;
  assign sel_sh = sel_d >>> 5;
  assign term_d = TERM_W'(sel_sh) * TERM_W'(SSG_GAIN);

`ifdef SSHOOTER_FM_LPF_EN
  logic signed [SAMPLE_W+FM_SHIFT-1:0] fm_acc_q, fm_acc_d;

  sshooter_onepole #(.SHIFT(FM_SHIFT)) u_fm (
    .acc_i      (fm_acc_q),
    .x_i        (fm_q),
    .y_o        (fm_term_d),
    .acc_next_o (fm_acc_d)
  );
`else
  assign fm_term_d = fm_q;
`endif

  assign sum_d = MIX_W'(fm_term_q) + MIX_W'(term_q[0]) + MIX_W'(term_q[1]) + MIX_W'(term_q[2]);
  assign s2_d  = {sum_d, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      fm_q      <= '0;
      fen_q     <= '0;
      fm_term_q <= '0;
      sound     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        ssg_q[i]    <= '0;
        dc_acc_q[i] <= '0;
        lp_acc_q[i] <= '0;
        term_q[i]   <= '0;
      end
`ifdef SSHOOTER_FM_LPF_EN
      fm_acc_q <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_cen && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (sample_cen) begin
            fm_q     <= fm_in;
            ssg_q[0] <= ssg_a;
            ssg_q[1] <= ssg_b;
            ssg_q[2] <= ssg_c;
            fen_q    <= filter_en;
            state_q  <= CH_A;
          end
        end
        CH_A, CH_B, CH_C: begin
          dc_acc_q[ch] <= dc_acc_d;
          lp_acc_q[ch] <= lp_acc_d;
          term_q[ch]   <= term_d;
          state_q      <= (state_q == CH_A) ? CH_B : (state_q == CH_B) ? CH_C : FM;
        end
        FM: begin
          fm_term_q <= fm_term_d;
`ifdef SSHOOTER_FM_LPF_EN
          fm_acc_q  <= fm_acc_d;
`endif
          state_q   <= MIX;
        end
        MIX: begin
          sound     <= sat16(s2_d);
          out_valid <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
